// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. A single result register holds the
// last accepted result until its owner consumes it, and a new operation may refill it in the
// same cycle the old result is drained.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,

  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_is_zero
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e      state_q;
  logic        out_owner_q;
  logic [31:0] out_result_q;
  logic        out_zero_q;
  logic        last_grant_q;

  logic out_valid;
  logic owner_ready;
  logic can_accept;
  logic grant0;
  logic grant1;
  logic accept;

  assign out_valid   = (state_q == StHold);
  assign owner_ready = out_owner_q ? resp1_ready : resp0_ready;
  // Draining the held result frees the register for a new capture in the same cycle.
  assign can_accept  = !out_valid || owner_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && can_accept) begin
      unique case ({req1_valid, req0_valid})
        2'b01: grant0 = 1'b1;
        2'b10: grant1 = 1'b1;
        2'b11: begin
          // last_grant_q == 0 means requester 0 won most recently, so requester 1 gets a turn.
          if (RR_EN && !last_grant_q) grant1 = 1'b1;
          else                        grant0 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_control = 4'b0000;
    if (grant0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_ctrl;
    end else if (grant1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      out_owner_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_zero_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      state_q      <= StHold;
      out_owner_q  <= grant1;
      out_result_q <= alu_result;
      out_zero_q   <= alu_is_zero;
      last_grant_q <= grant1;
    end else if (out_valid && owner_ready) begin
      state_q <= StIdle;
    end
  end

  assign resp0_valid = out_valid && !out_owner_q;
  assign resp1_valid = out_valid && out_owner_q;
  assign resp_result = out_result_q;
  assign resp_zero   = out_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and compares both
// against a cycle-level model of the arbitration and result-holding rules.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;

  logic        rr_req0_ready, rr_req1_ready, rr_resp0_valid, rr_resp1_valid, rr_resp_zero;
  logic [31:0] rr_resp_result, rr_alu_a, rr_alu_b, rr_alu_result;
  logic [3:0]  rr_alu_control;
  logic        rr_alu_is_zero;

  logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid, fp_resp_zero;
  logic [31:0] fp_resp_result, fp_alu_a, fp_alu_b, fp_alu_result;
  logic [3:0]  fp_alu_control;
  logic        fp_alu_is_zero;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference ALU used both as the shared ALU beside each DUT and for expected results.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] ctrl);
    case (ctrl)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1110: return b;
      default: return 32'd0;
    endcase
  endfunction

  assign rr_alu_result  = alu_ref(rr_alu_a, rr_alu_b, rr_alu_control);
  assign rr_alu_is_zero = (rr_alu_result == 32'd0);
  assign fp_alu_result  = alu_ref(fp_alu_a, fp_alu_b, fp_alu_control);
  assign fp_alu_is_zero = (fp_alu_result == 32'd0);

  alu_share_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp0_valid(rr_resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(rr_resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(rr_resp_result), .resp_zero(rr_resp_zero),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_control(rr_alu_control),
    .alu_result(rr_alu_result), .alu_is_zero(rr_alu_is_zero)
  );

  alu_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(fp_resp_result), .resp_zero(fp_resp_zero),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_control(fp_alu_control),
    .alu_result(fp_alu_result), .alu_is_zero(fp_alu_is_zero)
  );

  // Model state per instance: index 0 = round-robin, 1 = fixed priority.
  logic        m_valid [2];
  int          m_owner [2];
  int          m_last  [2];
  logic [31:0] m_result[2];
  logic        m_zero  [2];
  int          last_win[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = 4'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_ctrl = 4'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; checks, advances the model, and
  // returns at the next falling edge.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      string       p;
      logic        consume, room;
      int          win;
      logic [31:0] ea, eb, er;
      logic [3:0]  ec;
      logic        o_r0, o_r1, o_v0, o_v1, o_z;
      logic [31:0] o_res, o_a, o_b;
      logic [3:0]  o_c;
      p = (d == 0) ? "rr" : "fp";
      if (d == 0) begin
        o_r0 = rr_req0_ready; o_r1 = rr_req1_ready; o_v0 = rr_resp0_valid;
        o_v1 = rr_resp1_valid; o_z = rr_resp_zero; o_res = rr_resp_result;
        o_a = rr_alu_a; o_b = rr_alu_b; o_c = rr_alu_control;
      end else begin
        o_r0 = fp_req0_ready; o_r1 = fp_req1_ready; o_v0 = fp_resp0_valid;
        o_v1 = fp_resp1_valid; o_z = fp_resp_zero; o_res = fp_resp_result;
        o_a = fp_alu_a; o_b = fp_alu_b; o_c = fp_alu_control;
      end

      consume = m_valid[d] && ((m_owner[d] == 1) ? resp1_ready : resp0_ready);
      room    = !m_valid[d] || consume;
      win     = -1;
      if (!rst && room) begin
        if (req0_valid && req1_valid) win = (d == 0 && m_last[d] == 0) ? 1 : 0;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
      end
      last_win[d] = win;
      ea = (win == 0) ? req0_a : (win == 1) ? req1_a : 32'd0;
      eb = (win == 0) ? req0_b : (win == 1) ? req1_b : 32'd0;
      ec = (win == 0) ? req0_ctrl : (win == 1) ? req1_ctrl : 4'd0;

      check({p, "_req0_ready"}, 32'(o_r0), 32'(win == 0));
      check({p, "_req1_ready"}, 32'(o_r1), 32'(win == 1));
      check({p, "_resp0_valid"}, 32'(o_v0), 32'(m_valid[d] && m_owner[d] == 0));
      check({p, "_resp1_valid"}, 32'(o_v1), 32'(m_valid[d] && m_owner[d] == 1));
      check({p, "_resp_result"}, o_res, m_result[d]);
      check({p, "_resp_zero"}, 32'(o_z), 32'(m_zero[d]));
      check({p, "_alu_a"}, o_a, ea);
      check({p, "_alu_b"}, o_b, eb);
      check({p, "_alu_control"}, 32'(o_c), 32'(ec));

      if (rst) begin
        m_valid[d] = 1'b0; m_owner[d] = 0; m_result[d] = 32'd0; m_zero[d] = 1'b0;
        m_last[d]  = 1;
      end else if (win >= 0) begin
        er          = alu_ref(ea, eb, ec);
        m_valid[d]  = 1'b1;
        m_owner[d]  = win;
        m_result[d] = er;
        m_zero[d]   = (er == 32'd0);
        m_last[d]   = win;
      end else if (consume) begin
        m_valid[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    idle_inputs();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_owner[d] = 0; m_result[d] = 32'd0; m_zero[d] = 1'b0;
      m_last[d] = 1; last_win[d] = -1;
    end
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    check("reset_resp0_valid", 32'(rr_resp0_valid), 32'd0);
    check("reset_result", rr_resp_result, 32'd0);

    // 5 + 3 -> 8, accepted the same cycle, visible one cycle later.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0000;
    resp0_ready = 1'b1;
    step();
    check("add_ready", 32'(last_win[0]), 32'd0);
    check("add_resp0_valid", 32'(rr_resp0_valid), 32'd1);
    check("add_result", rr_resp_result, 32'd8);
    check("add_zero", 32'(rr_resp_zero), 32'd0);
    drain();

    // First contention after reset goes to req0; round-robin alternates, fixed stays on req0.
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    step();
    check("rr_first", 32'(last_win[0]), 32'd0);
    check("fp_first", 32'(last_win[1]), 32'd0);
    step();
    check("rr_second", 32'(last_win[0]), 32'd1);
    check("fp_second", 32'(last_win[1]), 32'd0);
    step();
    check("rr_third", 32'(last_win[0]), 32'd0);
    drain();

    // 7 - 7 -> zero result owned by req1.
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = 4'b1000;
    step();
    idle_inputs();
    check("sub_resp1_valid", 32'(rr_resp1_valid), 32'd1);
    check("sub_resp0_valid", 32'(rr_resp0_valid), 32'd0);
    check("sub_result", rr_resp_result, 32'd0);
    check("sub_zero", 32'(rr_resp_zero), 32'd1);
    drain();

    // Back-pressure: req0 holds its result for three cycles, then drain-and-refill by req1.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_ctrl = 4'b0000;
    step();
    req1_valid = 1'b1; req1_a = 32'd40; req1_b = 32'd2; req1_ctrl = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_result", rr_resp_result, 32'd10);
      check("hold_no_grant", 32'(last_win[0]), 32'hffff_ffff);
    end
    req0_valid = 1'b0; resp0_ready = 1'b1;
    step();
    check("refill_grant", 32'(last_win[0]), 32'd1);
    check("refill_owner", 32'(rr_resp1_valid), 32'd1);
    check("refill_result", rr_resp_result, 32'd42);

    // Reset while holding discards the result and restores req0 priority.
    idle_inputs();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_resp0_valid", 32'(rr_resp0_valid), 32'd0);
    check("rst_resp1_valid", 32'(rr_resp1_valid), 32'd0);
    check("rst_result", rr_resp_result, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    step();
    check("rst_contention", 32'(last_win[0]), 32'd0);
    drain();

    // Control code 1110 passes b through.
    req0_valid = 1'b1; req0_a = $urandom; req0_b = 32'h1234_5000; req0_ctrl = 4'b1110;
    step();
    check("passb_result", rr_resp_result, 32'h1234_5000);
    drain();

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req0_valid  = ($urandom_range(0, 2) != 0);
      req1_valid  = ($urandom_range(0, 2) != 0);
      req0_a      = $urandom;
      req0_b      = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
      req0_ctrl   = 4'($urandom_range(0, 15));
      req1_a      = $urandom;
      req1_b      = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
      req1_ctrl   = 4'($urandom_range(0, 15));
      resp0_ready = ($urandom_range(0, 1) == 1);
      resp1_ready = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-007 SHALL have ports reqN_ctrl  input  4  ALU control code of requester N.
REQ-008 SHALL have ports respN_valid  output  1  result held for requester N.
REQ-009 SHALL have ports respN_ready  input  1  requester N consumes its result.
REQ-010 SHALL have port resp_result  output  32  held result, shared by both response channels.
REQ-011 SHALL have port resp_zero  output  1  held zero flag.
REQ-012 SHALL have ports alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-013 SHALL have port alu_control  output  4  control code driven to the shared ALU.
REQ-014 SHALL have ports alu_result  input  32 and alu_is_zero  input  1  combinational ALU outputs.

Function
REQ-015 SHALL hold one output register set: out_valid, out_owner (1 bit), out_result, out_zero.
REQ-016 SHALL define states IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-017 SHALL compute can_accept = !out_valid OR (owner's respN_ready=1) in the same cycle, making drain-and-refill possible back-to-back.
REQ-018 SHALL grant at most one requester per cycle, and only when can_accept=1.
REQ-019 SHALL, with RR_EN=1 and both valid, grant the requester not granted most recently; last_grant resets to 1, so requester 0 wins first contention.
REQ-020 SHALL, with RR_EN=0, always grant requester 0 when both are valid.
REQ-021 SHALL, with a single valid requester, grant it regardless of last_grant.
REQ-022 SHALL assert reqN_ready combinationally only for the granted requester; reqN_ready SHALL NOT depend on reqN_ready of the other side.
REQ-023 SHALL drive alu_a/alu_b/alu_control from the granted request; with no grant, drive 0/0/4'b0000.
REQ-024 SHALL, on acceptance, capture alu_result/alu_is_zero into out_result/out_zero, set out_owner to the winner and out_valid=1; latency 1 cycle (result visible the cycle after handshake).
REQ-025 SHALL drive respN_valid = out_valid AND (out_owner==N); resp_result/resp_zero reflect the register at all times.
REQ-026 SHALL clear out_valid when the owner's respN_ready=1 and no new acceptance occurs in that cycle.
REQ-027 SHALL ignore respN_ready of the non-owner.
REQ-028 SHALL update last_grant only on an accepted request.
REQ-029 SHALL pass all control codes unmodified; it does not decode them.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set out_valid=0, out_owner=0, out_result=0, out_zero=0, last_grant=1.
REQ-031 SHALL hold reqN_ready=0 during any cycle in which rst=1.
REQ-032 SHALL discard a held, unconsumed result on reset; no response for it is ever issued.

Verification
REQ-033 SHALL verify: req0 a=5, b=3, ctrl=0000, resp0_ready=1 -> req0_ready=1 same cycle; next cycle resp0_valid=1, resp_result=8, resp_zero=0.
REQ-034 SHALL verify: after reset, req0 and req1 both valid (RR_EN=1) -> req0 granted first, req1 next cycle; with RR_EN=0 and both held valid -> req0 always granted.
REQ-035 SHALL verify: req1 a=7, b=7, ctrl=1000 -> resp1_valid=1, resp_result=0, resp_zero=1; resp0_valid stays 0.
REQ-036 SHALL verify: result held for req0 with resp0_ready=0 for 3 cycles -> resp_result stable, req0_ready=req1_ready=0; raise resp0_ready with req1 valid -> req1 accepted the same cycle.
REQ-037 SHALL verify: rst=1 while HOLD -> next cycle resp0_valid=resp1_valid=0, resp_result=0, and first later contention is won by req0.
REQ-038 SHALL verify: ctrl=1110, b=32'h12345000 -> resp_result=32'h12345000.
